wave_sequencer: RTL and testbench
=================================

# wave_sequencer

Address sequencer and playback controller for the 16-entry waveform sample `memory` of the generator. It steps the memory `address` at a programmable rate and stride, in continuous or one-shot mode. It tracks the memory read latency, so every emitted sample carries a one-cycle `sample_valid` strobe. It sits between the control/register front end and the `memory` block, and feeds the DAC output path.

## Interface
- `ADDR_W`, 4, memory address width; depth = 2^ADDR_W.
- `SAMPLE_W`, 12, sample width.
- `DIV_W`, 16, rate divider width.
- `MEM_LAT`, 1, `memory` read latency in cycles (address to `mem_sample`), ≥1.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin playback; sampled only in IDLE.
- `stop`  in  1  abort playback; sampled in RUN; has priority over `start`.
- `one_shot`  in  1  1 = single pass, 0 = continuous; latched at start.
- `divider`  in  DIV_W  advance the address every `divider`+1 cycles; latched at start.
- `step`  in  ADDR_W  address stride; 0 is treated as 1; latched at start.
- `address`  out  ADDR_W  to `memory.address`.
- `mem_sample`  in  SAMPLE_W  from `memory.sample`.
- `sample_out`  out  SAMPLE_W  registered sample.
- `sample_valid`  out  1  one-cycle strobe; `sample_out` is new.
- `busy`  out  1  high in RUN and DRAIN.
- `wrap`  out  1  one-cycle pulse when `address` wraps (continuous mode only).
- `done`  out  1  one-cycle pulse on return to IDLE.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE, `start`=1 and `stop`=0:
  - latch `div_q`, `step_q` (0→1) and `os_q`;
  - `address`←0, `cnt`←0;
  - issue a read; go to RUN.
- IDLE, `start`=1 and `stop`=1: stay in IDLE.
- RUN, `stop`=1: go to DRAIN. No further issue; `address` holds.
- RUN, `cnt`≠`div_q`: `cnt`←`cnt`+1.
- RUN, `cnt`=`div_q`: `cnt`←0, and `nxt` = `address`+`step_q`, computed ADDR_W+1 bits wide.
  - No carry out: `address`←`nxt`, issue.
  - Carry and `os_q`=0: `address`←`nxt` mod 2^ADDR_W, issue, `wrap` pulses with the new address.
  - Carry and `os_q`=1: `address` holds, no issue, go to DRAIN.
- `start` is ignored in RUN and DRAIN. Parameter inputs are ignored outside IDLE.
- Issue tracking uses an (MEM_LAT+1)-deep shift register.
  - `sample_out` captures `mem_sample` MEM_LAT cycles after the issue cycle.
  - `sample_valid` is high the following cycle.
  - Every issue yields exactly one `sample_valid`, including issues made just before `stop`.
- DRAIN: wait until no issue is in flight. Then go to IDLE with `done`=1 for one cycle. `done` is never coincident with or before the last `sample_valid`.
- `rst` low at any time clears everything immediately:
  - state → IDLE;
  - `address`=0, `sample_out`=0;
  - `sample_valid`, `busy`, `wrap`, `done` = 0;
  - `cnt`, latched parameters and the issue pipeline cleared.
  - In-flight samples are discarded and no `done` is generated.

## Timing
- Start accepted at edge of cycle T. `busy`=1 and `address`=0 in T+1.
- The first `sample_valid` is in T+2+MEM_LAT, i.e. T+3 at default.
- Address change to `sample_valid`: MEM_LAT+1 cycles.
- Address period: `div_q`+1 cycles. `divider`=0 gives one sample per cycle, back-to-back.
- `wrap` is high in the same cycle that `address` shows the wrapped value.
- One-shot with stride s: exactly ceil(16/s) samples (for s≥1), at addresses 0, s, 2s, … <16.
- After `stop` at edge E:
  - the last `sample_valid` occurs ≤ E+MEM_LAT+1;
  - `done` follows 1 cycle after the pipeline empties;
  - `busy` falls together with `done` rising.
- A new `start` is accepted in the cycle `done` is high.

## Test plan
- Reset: hold `rst`=0 for 5 cycles, then release → all outputs 0, state IDLE, no strobes for 10 idle cycles.
- Continuous, `divider`=0, `step`=1, memory preloaded with sample=16×addr:
  - `address` 0,1,…,15,0,1…, one per cycle;
  - `sample_valid` continuous from T+3 with `sample_out` 0,16,…,240,0;
  - `wrap` pulses once per 16 cycles with `address`=0.
- `divider`=3, `step`=1:
  - `address` changes every 4 cycles;
  - `sample_valid` pulses every 4 cycles, 2 cycles after each change.
- One-shot, `step`=4, `divider`=1:
  - addresses 0,4,8,12 → exactly 4 `sample_valid`, no `wrap`;
  - `done` 1 cycle after the last valid; `busy` low afterwards.
- `stop` asserted 1 cycle after an issue with `divider`=0:
  - the in-flight sample still produces `sample_valid`;
  - no further address change, then `done`;
  - `start`+`stop` together in IDLE → stays IDLE, `busy`=0.
- `rst` pulled low mid-RUN with 2 samples in flight → outputs cleared immediately, no `sample_valid` or `done` afterwards; `start` after release restarts from `address`=0.

Source files
------------

// File: rtl/wave_sequencer_if.sv
// Control, memory and output signals of the waveform address sequencer.
// The sequencer takes the slave side; the memory/front-end driver takes the master side.
interface wave_sequencer_if #(
  parameter int ADDR_W   = 4,
  parameter int SAMPLE_W = 12,
  parameter int DIV_W    = 16
);
  logic                start;
  logic                stop;
  logic                one_shot;
  logic [DIV_W-1:0]    divider;
  logic [ADDR_W-1:0]   step;
  logic [ADDR_W-1:0]   address;
  logic [SAMPLE_W-1:0] mem_sample;
  logic [SAMPLE_W-1:0] sample_out;
  logic                sample_valid;
  logic                busy;
  logic                wrap;
  logic                done;

  modport master (
    output start, stop, one_shot, divider, step, mem_sample,
    input  address, sample_out, sample_valid, busy, wrap, done
  );

  modport slave (
    input  start, stop, one_shot, divider, step, mem_sample,
    output address, sample_out, sample_valid, busy, wrap, done
  );
endinterface

// File: rtl/wave_sequencer.sv
// Waveform memory address sequencer: programmable rate/stride playback with
// read-latency tracking so every issued address yields one sample_valid strobe.
module wave_sequencer #(
  parameter int ADDR_W   = 4,
  parameter int SAMPLE_W = 12,
  parameter int DIV_W    = 16,
  parameter int MEM_LAT  = 1
) (
  input logic              clk,
  input logic              rst,
  wave_sequencer_if.slave  bus
);
  localparam int STAGES = MEM_LAT;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr_q, addr_n, step_q;
  logic [DIV_W-1:0]    div_q, cnt, cnt_n;
  logic                os_q;
  logic [STAGES:0]     vld_pipe;
  logic [SAMPLE_W-1:0] sample_q;
  logic                valid_q, wrap_q, done_q;
  logic                issue, load, wrap_n, done_n;
  logic [ADDR_W:0]     nxt;

  // One extra bit catches the carry that marks the end of a pass.
  assign nxt = {1'b0, addr_q} + {1'b0, step_q};

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    cnt_n   = cnt;
    issue   = 1'b0;
    load    = 1'b0;
    wrap_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: if (bus.start && !bus.stop) begin
        load    = 1'b1;
        addr_n  = '0;
        cnt_n   = '0;
        issue   = 1'b1;
        state_n = RUN;
      end
      RUN: begin
        if (bus.stop) begin
          state_n = DRAIN;
        end else if (cnt != div_q) begin
          cnt_n = cnt + DIV_W'(1);
        end else begin
          cnt_n = '0;
          if (!nxt[ADDR_W]) begin
            addr_n = nxt[ADDR_W-1:0];
            issue  = 1'b1;
          end else if (!os_q) begin
            addr_n = nxt[ADDR_W-1:0];
            issue  = 1'b1;
            wrap_n = 1'b1;
          end else begin
            state_n = DRAIN;
          end
        end
      end
      // Hold off done until every issued read has produced its strobe.
      DRAIN: if (vld_pipe == '0) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      cnt      <= '0;
      div_q    <= '0;
      step_q   <= '0;
      os_q     <= 1'b0;
      vld_pipe <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      addr_q   <= addr_n;
      cnt      <= cnt_n;
      wrap_q   <= wrap_n;
      done_q   <= done_n;
      vld_pipe <= {vld_pipe[STAGES-1:0], issue};
      valid_q  <= vld_pipe[STAGES];
      if (vld_pipe[STAGES]) sample_q <= bus.mem_sample;
      if (load) begin
        div_q  <= bus.divider;
        step_q <= (bus.step == '0) ? ADDR_W'(1) : bus.step;
        os_q   <= bus.one_shot;
      end
    end
  end

  assign bus.address      = addr_q;
  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy         = (state != IDLE);
  assign bus.wrap         = wrap_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_wave_sequencer.sv
// Bench for wave_sequencer: directed table of playback runs, hand-written corner
// sequences, and randomized runs checked cycle by cycle against an arithmetic model.
module tb_wave_sequencer;
  localparam int ADDR_W   = 4;
  localparam int SAMPLE_W = 12;
  localparam int DIV_W    = 16;
  localparam int MEM_LAT  = 1;

  typedef struct {
    int div;
    int stp;
    bit os;
    int stop_rel;
    int exp_nv;
    int exp_nw;
    int exp_drel;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [SAMPLE_W-1:0] mem [16];

  wave_sequencer_if #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W), .DIV_W(DIV_W)) bus ();

  wave_sequencer #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W), .DIV_W(DIV_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Single-cycle-latency waveform memory.
  always @(posedge clk) bus.mem_sample <= mem[bus.address];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " sample_valid"}, bus.sample_valid, 0);
    chk({tag, " wrap"}, bus.wrap, 0);
    chk({tag, " done"}, bus.done, 0);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk(tag, seen, 1);
  endtask

  // One playback run. Expectations come from the playback rules: issue j lands at
  // relative cycle j*(div+1) with address (j*s) mod 16, its sample strobes two
  // cycles later, and done follows once both the run has ended and the last
  // sample has emerged.
  task automatic run(input int div, input int stp, input bit os, input int stop_rel,
                     output int nv, output int nw, output int drel);
    int s, p, n, c_l, d_rel, j, jv, ea;
    bit ev, ew;
    s   = (stp == 0) ? 1 : stp;
    p   = div + 1;
    n   = os ? (16 + s - 1) / s : stop_rel / p + 1;
    c_l = (n - 1) * p;
    if (os) d_rel = ((n * p > c_l + 2) ? n * p : c_l + 2) + 1;
    else    d_rel = ((stop_rel + 1 > c_l + 2) ? stop_rel + 1 : c_l + 2) + 1;
    nv = 0; nw = 0; drel = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.divider = DIV_W'(div); bus.step = ADDR_W'(stp); bus.one_shot = os;
    @(negedge clk);
    // Parameter inputs are scrambled while running; the latched copies must win.
    bus.start = 1'b0; bus.divider = DIV_W'($urandom); bus.step = ADDR_W'($urandom);
    bus.one_shot = 1'($urandom);
    for (int r = 0; r <= d_rel + 2; r++) begin
      bus.stop = !os && (r == stop_rel);
      j  = (r / p < n) ? r / p : n - 1;
      ea = (j * s) % 16;
      jv = (r >= 2) ? (r - 2) / p : 0;
      ev = (r >= 2) && ((r - 2) % p == 0) && (jv < n);
      ew = !os && (r % p == 0) && (r / p >= 1) && (r / p < n) &&
           (((r / p) * s) / 16 != ((r / p - 1) * s) / 16);
      chk($sformatf("address r%0d", r), bus.address, ea);
      chk($sformatf("sample_valid r%0d", r), bus.sample_valid, ev);
      chk($sformatf("wrap r%0d", r), bus.wrap, ew);
      chk($sformatf("busy r%0d", r), bus.busy, r < d_rel);
      chk($sformatf("done r%0d", r), bus.done, r == d_rel);
      if (ev) chk($sformatf("sample_out r%0d", r), bus.sample_out, mem[(jv * s) % 16]);
      if (bus.sample_valid) nv++;
      if (bus.wrap) nw++;
      if (bus.done && drel < 0) drel = r;
      @(negedge clk);
    end
    bus.stop = 1'b0;
  endtask

  initial begin
    vec_t tbl[8];
    int nv, nw, drel;
    bit ok;

    //          div stp os stop  nv  nw drel
    tbl[0] = '{0,  1, 1'b0, 19, 20, 1, 22};
    tbl[1] = '{3,  1, 1'b0, 13,  4, 0, 15};
    tbl[2] = '{1,  4, 1'b1,  0,  4, 0,  9};
    tbl[3] = '{0,  0, 1'b1,  0, 16, 0, 18};
    tbl[4] = '{0,  5, 1'b1,  0,  4, 0,  6};
    tbl[5] = '{2,  3, 1'b0, 20,  7, 1, 22};
    tbl[6] = '{0, 15, 1'b1,  0,  2, 0,  4};
    tbl[7] = '{0,  1, 1'b0, 40, 41, 2, 43};

    bus.start = 1'b0; bus.stop = 1'b0; bus.one_shot = 1'b0;
    bus.divider = '0; bus.step = '0;
    for (int a = 0; a < 16; a++) mem[a] = SAMPLE_W'(16 * a);

    // Reset state
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset address", bus.address, 0);
    chk("reset sample_out", bus.sample_out, 0);
    idle_chk("reset");
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post-reset address", bus.address, 0);
      idle_chk("post-reset");
    end

    // Directed runs
    for (int i = 0; i < 8; i++) begin
      run(tbl[i].div, tbl[i].stp, tbl[i].os, tbl[i].stop_rel, nv, nw, drel);
      chk($sformatf("vec%0d valid count", i), nv, tbl[i].exp_nv);
      chk($sformatf("vec%0d wrap count", i), nw, tbl[i].exp_nw);
      chk($sformatf("vec%0d done cycle", i), drel, tbl[i].exp_drel);
    end

    // start together with stop in IDLE: stays idle, address holds at 8
    @(negedge clk);
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    repeat (3) begin
      chk("start+stop address", bus.address, 8);
      idle_chk("start+stop");
      @(negedge clk);
    end

    // New start accepted in the cycle done is high
    bus.start = 1'b1; bus.one_shot = 1'b1; bus.divider = '0; bus.step = 4'd8;
    @(negedge clk);
    bus.start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.done) ok = 1'b1;
      else @(negedge clk);
    end
    chk("restart done seen", ok, 1);
    chk("restart busy at done", bus.busy, 0);
    bus.start = 1'b1; bus.one_shot = 1'b0; bus.step = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("restart busy", bus.busy, 1);
    chk("restart address", bus.address, 0);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    wait_done("restart stop done");

    // Reset mid-run with samples in flight
    for (int a = 0; a < 16; a++) mem[a] = SAMPLE_W'(16 * a + 7);
    @(negedge clk);
    bus.start = 1'b1; bus.one_shot = 1'b0; bus.divider = '0; bus.step = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset valid", bus.sample_valid, 1);
    rst = 1'b0;
    #1;
    chk("async reset address", bus.address, 0);
    chk("async reset sample_out", bus.sample_out, 0);
    idle_chk("async reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("after reset address", bus.address, 0);
      idle_chk("after reset");
    end
    bus.start = 1'b1; bus.divider = 16'd1; bus.step = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rerun address", bus.address, 0);
    chk("rerun busy", bus.busy, 1);
    @(negedge clk);
    @(negedge clk);
    chk("rerun first valid", bus.sample_valid, 1);
    chk("rerun first sample", bus.sample_out, 7);
    chk("rerun address step", bus.address, 2);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    wait_done("rerun done");

    // Randomized runs against the model
    for (int t = 0; t < 20; t++) begin
      for (int a = 0; a < 16; a++) mem[a] = SAMPLE_W'($urandom);
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 40)), nv, nw, drel);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
